// File: rtl/blk_mem_arbiter.sv
// rtl/blk_mem_arbiter.sv - arbitrates NUM_CH block requesters onto one block memory port
// Round-robin or fixed-priority grant, registered address/data, optional ISSUE watchdog.
module blk_mem_arbiter #(
  parameter int NUM_CH  = 3,
  parameter int ADDR_W  = 32,
  parameter int BLK_W   = 256,
  parameter int RR_EN   = 1,
  parameter int TIMEOUT = 0
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic [NUM_CH-1:0]        ch_req,
  input  logic [NUM_CH-1:0]        ch_we,
  input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
  input  logic [NUM_CH*BLK_W-1:0]  ch_wdata,
  output logic [BLK_W-1:0]         ch_rdata,
  output logic [NUM_CH-1:0]        ch_done,
  output logic                     ch_err,
  output logic                     mem_read_req,
  output logic                     mem_write_req,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [BLK_W-1:0]         mem_write_data,
  input  logic [BLK_W-1:0]         mem_read_data,
  input  logic                     mem_read_valid,
  input  logic                     mem_write_valid,
  output logic                     busy
);

  localparam int IDX_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CW       = IDX_W + 1;
  localparam int TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int TMO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t              r_state;
  logic [IDX_W-1:0]    r_ptr;
  logic [IDX_W-1:0]    r_gnt;
  logic                r_we;
  logic [TW-1:0]       r_timer;
  logic                r_mem_read_req;
  logic                r_mem_write_req;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [BLK_W-1:0]    r_mem_write_data;
  logic [BLK_W-1:0]    r_ch_rdata;
  logic [NUM_CH-1:0]   r_ch_done;
  logic                r_ch_err;

  logic [ADDR_W-1:0]   w_addr_arr  [NUM_CH];
  logic [BLK_W-1:0]    w_wdata_arr [NUM_CH];
  logic [IDX_W-1:0]    w_base;
  logic [IDX_W-1:0]    w_gnt;
  logic [IDX_W-1:0]    w_ptr_nxt;
  logic [CW-1:0]       w_cand;
  logic                w_found;
  logic                w_valid;
  logic                w_tmo;
  logic [NUM_CH-1:0]   w_gnt_oh;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
    assign w_addr_arr[gi]  = ch_addr[gi*ADDR_W +: ADDR_W];
    assign w_wdata_arr[gi] = ch_wdata[gi*BLK_W +: BLK_W];
  end

  // Scan from the base index with wrap; fixed priority is simply a base of 0.
  always_comb begin
    w_base  = (RR_EN != 0) ? r_ptr : '0;
    w_gnt   = '0;
    w_found = 1'b0;
    w_cand  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_cand = {1'b0, w_base} + CW'(i);
      if (w_cand >= CW'(NUM_CH)) begin
        w_cand = w_cand - CW'(NUM_CH);
      end
      if (!w_found && ch_req[w_cand[IDX_W-1:0]]) begin
        w_found = 1'b1;
        w_gnt   = w_cand[IDX_W-1:0];
      end
    end
  end

  assign w_ptr_nxt = (w_gnt == IDX_W'(NUM_CH - 1)) ? '0 : w_gnt + IDX_W'(1);
  assign w_valid   = r_we ? mem_write_valid : mem_read_valid;
  assign w_tmo     = (TIMEOUT > 0) && (r_timer == TW'(TMO_LAST));
  assign w_gnt_oh  = {{(NUM_CH-1){1'b0}}, 1'b1} << r_gnt;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state          <= ST_IDLE;
      r_ptr            <= '0;
      r_gnt            <= '0;
      r_we             <= 1'b0;
      r_timer          <= '0;
      r_mem_read_req   <= 1'b0;
      r_mem_write_req  <= 1'b0;
      r_mem_addr       <= '0;
      r_mem_write_data <= '0;
      r_ch_rdata       <= '0;
      r_ch_done        <= '0;
      r_ch_err         <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_gnt      <= w_gnt;
            r_we       <= ch_we[w_gnt];
            r_mem_addr <= w_addr_arr[w_gnt];
            r_timer    <= '0;
            if (ch_we[w_gnt]) begin
              r_mem_write_data <= w_wdata_arr[w_gnt];
              r_mem_write_req  <= 1'b1;
            end else begin
              r_mem_read_req   <= 1'b1;
            end
            if (RR_EN != 0) begin
              r_ptr <= w_ptr_nxt;
            end
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // A valid arriving on the expiry cycle still completes normally.
          if (w_valid || w_tmo) begin
            r_mem_read_req  <= 1'b0;
            r_mem_write_req <= 1'b0;
            r_ch_done       <= w_gnt_oh;
            r_ch_err        <= !w_valid;
            if (w_valid && !r_we) begin
              r_ch_rdata <= mem_read_data;
            end
            r_state <= ST_DONE;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        ST_DONE: begin
          r_ch_done <= '0;
          r_ch_err  <= 1'b0;
          r_state   <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign mem_read_req   = r_mem_read_req;
  assign mem_write_req  = r_mem_write_req;
  assign mem_addr       = r_mem_addr;
  assign mem_write_data = r_mem_write_data;
  assign ch_rdata       = r_ch_rdata;
  assign ch_done        = r_ch_done;
  assign ch_err         = r_ch_err;
  assign busy           = (r_state != ST_IDLE);

endmodule

// File: tb/tb_blk_mem_arbiter.sv
// tb/tb_blk_mem_arbiter.sv - directed bench for blk_mem_arbiter
// Instance a: round-robin with TIMEOUT=8; instance b: fixed priority, no watchdog; both share stimulus.
module tb_blk_mem_arbiter;

  localparam logic [31:0]  A0 = 32'h1000_0000;
  localparam logic [31:0]  A1 = 32'h1000_0100;
  localparam logic [31:0]  A2 = 32'h1000_0200;
  localparam logic [255:0] WD0 = {8{32'hC0DE_0000}};
  localparam logic [255:0] WD1 = {8{32'hC0DE_0001}};
  localparam logic [255:0] WD2 = {8{32'hC0DE_0002}};
  localparam logic [255:0] PAT = {16{16'h3C96}};
  localparam logic [255:0] RA5 = {32{8'hA5}};
  localparam logic [255:0] R77 = {32{8'h77}};

  logic         CLK;
  logic         RESET;
  logic [2:0]   ch_req;
  logic [2:0]   ch_we;
  logic [95:0]  ch_addr;
  logic [767:0] ch_wdata;
  logic [255:0] mem_read_data;
  logic         mem_read_valid;
  logic         mem_write_valid;

  logic [255:0] a_rdata, b_rdata, a_wdata, b_wdata;
  logic [2:0]   a_done, b_done;
  logic         a_err, b_err, a_rreq, b_rreq, a_wreq, b_wreq, a_busy, b_busy;
  logic [31:0]  a_addr, b_addr;

  int n_chk  = 0;
  int n_fail = 0;
  int n_excl = 0;

  typedef struct {
    logic [2:0] req;
    logic [2:0] we;
    logic [1:0] ga;
    logic [1:0] gb;
  } vec_t;
  vec_t tbl [15];

  blk_mem_arbiter #(.NUM_CH(3), .ADDR_W(32), .BLK_W(256), .RR_EN(1), .TIMEOUT(8)) u_a (
    .CLK(CLK), .RESET(RESET), .ch_req(ch_req), .ch_we(ch_we), .ch_addr(ch_addr),
    .ch_wdata(ch_wdata), .ch_rdata(a_rdata), .ch_done(a_done), .ch_err(a_err),
    .mem_read_req(a_rreq), .mem_write_req(a_wreq), .mem_addr(a_addr),
    .mem_write_data(a_wdata), .mem_read_data(mem_read_data),
    .mem_read_valid(mem_read_valid), .mem_write_valid(mem_write_valid), .busy(a_busy)
  );

  blk_mem_arbiter #(.NUM_CH(3), .ADDR_W(32), .BLK_W(256), .RR_EN(0), .TIMEOUT(0)) u_b (
    .CLK(CLK), .RESET(RESET), .ch_req(ch_req), .ch_we(ch_we), .ch_addr(ch_addr),
    .ch_wdata(ch_wdata), .ch_rdata(b_rdata), .ch_done(b_done), .ch_err(b_err),
    .mem_read_req(b_rreq), .mem_write_req(b_wreq), .mem_addr(b_addr),
    .mem_write_data(b_wdata), .mem_read_data(mem_read_data),
    .mem_read_valid(mem_read_valid), .mem_write_valid(mem_write_valid), .busy(b_busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if ((a_rreq && a_wreq) || (b_rreq && b_wreq)) n_excl++;
  end

  function automatic logic [31:0] addr_of(input logic [1:0] g);
    case (g)
      2'd0:    return A0;
      2'd1:    return A1;
      default: return A2;
    endcase
  endfunction

  function automatic logic [255:0] wd_of(input logic [1:0] g);
    case (g)
      2'd0:    return WD0;
      2'd1:    return WD1;
      default: return WD2;
    endcase
  endfunction

  task automatic chkw(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b", nm, act, exp);
    end
  endtask

  initial begin
    logic [2:0] ea, eb;
    logic       early;
    int         pulses;

    tbl[0]  = '{3'b111, 3'b000, 2'd0, 2'd0};
    tbl[1]  = '{3'b111, 3'b000, 2'd1, 2'd0};
    tbl[2]  = '{3'b111, 3'b000, 2'd2, 2'd0};
    tbl[3]  = '{3'b111, 3'b000, 2'd0, 2'd0};
    tbl[4]  = '{3'b111, 3'b000, 2'd1, 2'd0};
    tbl[5]  = '{3'b111, 3'b000, 2'd2, 2'd0};
    tbl[6]  = '{3'b110, 3'b000, 2'd1, 2'd1};
    tbl[7]  = '{3'b110, 3'b000, 2'd2, 2'd1};
    tbl[8]  = '{3'b110, 3'b000, 2'd1, 2'd1};
    tbl[9]  = '{3'b100, 3'b000, 2'd2, 2'd2};
    tbl[10] = '{3'b011, 3'b000, 2'd0, 2'd0};
    tbl[11] = '{3'b010, 3'b010, 2'd1, 2'd1};
    tbl[12] = '{3'b101, 3'b101, 2'd2, 2'd0};
    tbl[13] = '{3'b001, 3'b000, 2'd0, 2'd0};
    tbl[14] = '{3'b100, 3'b100, 2'd2, 2'd2};

    RESET = 1'b0; ch_req = '0; ch_we = '0;
    ch_addr  = {A2, A1, A0};
    ch_wdata = {WD2, WD1, WD0};
    mem_read_data = '0; mem_read_valid = 1'b0; mem_write_valid = 1'b0;

    repeat (2) @(negedge CLK);
    chk1("rst_rreq", a_rreq, 1'b0);
    chk1("rst_wreq", a_wreq, 1'b0);
    chk1("rst_busy", a_busy, 1'b0);
    chkw("rst_done", 256'(a_done), 256'(0));
    chkw("rst_addr", 256'(a_addr), 256'(0));
    chkw("rst_wdata", a_wdata, '0);
    chkw("rst_rdata", a_rdata, '0);
    chk1("rst_b_busy", b_busy, 1'b0);

    // Memory answers immediately: each transaction takes exactly three cycles.
    RESET = 1'b1; mem_read_valid = 1'b1; mem_write_valid = 1'b1;
    for (int k = 0; k < 15; k++) begin
      ch_req = tbl[k].req; ch_we = tbl[k].we;
      mem_read_data = {8{32'hBEEF_0000 + 32'(k)}};
      ea = 3'(1) << tbl[k].ga;
      eb = 3'(1) << tbl[k].gb;
      @(negedge CLK);
      chkw($sformatf("v%0d_a_addr", k), 256'(a_addr), 256'(addr_of(tbl[k].ga)));
      chkw($sformatf("v%0d_b_addr", k), 256'(b_addr), 256'(addr_of(tbl[k].gb)));
      chk1($sformatf("v%0d_a_wreq", k), a_wreq, tbl[k].we[tbl[k].ga]);
      chk1($sformatf("v%0d_a_rreq", k), a_rreq, !tbl[k].we[tbl[k].ga]);
      chk1($sformatf("v%0d_b_wreq", k), b_wreq, tbl[k].we[tbl[k].gb]);
      if (tbl[k].we[tbl[k].ga]) chkw($sformatf("v%0d_a_wdata", k), a_wdata, wd_of(tbl[k].ga));
      @(negedge CLK);
      chkw($sformatf("v%0d_a_done", k), 256'(a_done), 256'(ea));
      chkw($sformatf("v%0d_b_done", k), 256'(b_done), 256'(eb));
      chk1($sformatf("v%0d_a_err", k), a_err, 1'b0);
      if (!tbl[k].we[tbl[k].ga]) chkw($sformatf("v%0d_a_rdata", k), a_rdata, mem_read_data);
      @(negedge CLK);
      chkw($sformatf("v%0d_a_done_off", k), 256'(a_done), 256'(0));
      chk1($sformatf("v%0d_a_idle", k), a_busy, 1'b0);
    end

    // Single read, valid five cycles after the request rises.
    ch_req = '0; ch_we = '0; mem_read_valid = 1'b0; mem_write_valid = 1'b0;
    ch_addr[31:0] = 32'h0040_0020;
    ch_req = 3'b001;
    @(negedge CLK);
    chk1("rd_rreq", a_rreq, 1'b1);
    chk1("rd_wreq", a_wreq, 1'b0);
    chkw("rd_addr", 256'(a_addr), 256'(32'h0040_0020));
    repeat (4) @(negedge CLK);
    chkw("rd_wait_done", 256'(a_done), 256'(0));
    mem_read_valid = 1'b1; mem_read_data = RA5;
    @(negedge CLK);
    chkw("rd_done", 256'(a_done), 256'(3'b001));
    chkw("rd_rdata", a_rdata, RA5);
    chk1("rd_req_drop", a_rreq, 1'b0);
    mem_read_valid = 1'b0; mem_read_data = '0; ch_req = '0;
    @(negedge CLK);
    chkw("rd_done_1cyc", 256'(a_done), 256'(0));
    chk1("rd_busy_low", a_busy, 1'b0);

    // Single write with a stray read valid, and inputs changed after grant.
    ch_wdata[256 +: 256] = PAT; ch_req = 3'b010; ch_we = 3'b010;
    @(negedge CLK);
    chk1("wr_wreq", a_wreq, 1'b1);
    chk1("wr_rreq", a_rreq, 1'b0);
    chkw("wr_wdata", a_wdata, PAT);
    ch_wdata[256 +: 256] = ~PAT; ch_addr[63:32] = 32'hDEAD_BEEF;
    mem_read_valid = 1'b1; mem_read_data = {32{8'h11}};
    @(negedge CLK);
    chkw("wr_stray_done", 256'(a_done), 256'(0));
    chkw("wr_hold_wdata", a_wdata, PAT);
    chkw("wr_hold_addr", 256'(a_addr), 256'(A1));
    mem_read_valid = 1'b0; mem_write_valid = 1'b1;
    @(negedge CLK);
    chkw("wr_done", 256'(a_done), 256'(3'b010));
    chk1("wr_err", a_err, 1'b0);
    chkw("wr_rdata_keep", a_rdata, RA5);
    mem_write_valid = 1'b0; ch_req = '0; ch_we = '0; ch_addr[63:32] = A1;
    @(negedge CLK);

    // Watchdog expiry with no valid.
    ch_req = 3'b001; mem_read_data = R77;
    @(negedge CLK);
    chk1("tmo_rreq", a_rreq, 1'b1);
    early = 1'b0;
    repeat (7) begin
      @(negedge CLK);
      if (a_done != 3'b000) early = 1'b1;
    end
    chk1("tmo_early", early, 1'b0);
    @(negedge CLK);
    chkw("tmo_done", 256'(a_done), 256'(3'b001));
    chk1("tmo_err", a_err, 1'b1);
    chk1("tmo_req_drop", a_rreq, 1'b0);
    chkw("tmo_rdata_keep", a_rdata, RA5);
    ch_req = '0;
    @(negedge CLK);
    chk1("tmo_err_off", a_err, 1'b0);
    chk1("tmo_idle", a_busy, 1'b0);

    // Valid on the expiry cycle wins.
    ch_req = 3'b001;
    @(negedge CLK);
    chk1("v8_rreq", a_rreq, 1'b1);
    repeat (7) @(negedge CLK);
    chkw("v8_early", 256'(a_done), 256'(0));
    mem_read_valid = 1'b1;
    @(negedge CLK);
    chkw("v8_done", 256'(a_done), 256'(3'b001));
    chk1("v8_err", a_err, 1'b0);
    chkw("v8_rdata", a_rdata, R77);
    mem_read_valid = 1'b0; ch_req = '0;
    @(negedge CLK);

    // Asynchronous reset during a pending write.
    ch_req = 3'b001; ch_we = 3'b001;
    @(negedge CLK);
    chk1("rs_wreq_pre", a_wreq, 1'b1);
    #2 RESET = 1'b0;
    #1;
    chk1("rs_wreq", a_wreq, 1'b0);
    chk1("rs_busy", a_busy, 1'b0);
    chkw("rs_addr", 256'(a_addr), 256'(0));
    chkw("rs_wdata", a_wdata, '0);
    chkw("rs_rdata", a_rdata, '0);
    chk1("rs_b_wreq", b_wreq, 1'b0);
    ch_req = '0; ch_we = '0;
    pulses = 0;
    repeat (2) begin
      @(negedge CLK);
      if (a_done != 3'b000 || b_done != 3'b000) pulses++;
    end
    chkw("rs_no_done", 256'(pulses), 256'(0));
    ch_req = 3'b101; mem_read_valid = 1'b1; RESET = 1'b1;
    @(negedge CLK);
    chkw("rs_ptr0_addr", 256'(a_addr), 256'(32'h0040_0020));
    chkw("rs_no_done2", 256'(a_done), 256'(0));
    @(negedge CLK);
    chkw("rs_ptr0_done", 256'(a_done), 256'(3'b001));
    ch_req = 3'b100;
    @(negedge CLK);
    @(negedge CLK);
    chkw("rs_ch2_addr", 256'(a_addr), 256'(A2));
    @(negedge CLK);
    chkw("rs_ch2_done", 256'(a_done), 256'(3'b100));
    chkw("rs_ch2_b_done", 256'(b_done), 256'(3'b100));
    ch_req = '0; mem_read_valid = 1'b0;
    @(negedge CLK);

    chkw("req_exclusive", 256'(n_excl), 256'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
